// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and Booth recoding for the radix-4 multiplier
package mul_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;

    typedef enum logic [2:0] {OP_ZERO, OP_ADD1, OP_ADD2, OP_SUB1, OP_SUB2} booth_op_e;

    // Radix-4 Booth recoding of {b[i+1], b[i], b[i-1]}.
    function automatic booth_op_e booth_decode(input logic [2:0] bits);
        booth_op_e op;
        case (bits)
            3'b001, 3'b010: op = OP_ADD1;
            3'b011:         op = OP_ADD2;
            3'b100:         op = OP_SUB2;
            3'b101, 3'b110: op = OP_SUB1;
            default:        op = OP_ZERO;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mul_booth4_step.sv
// rtl/mul_booth4_step.sv - one radix-4 Booth step: add/sub into upper half, then shift right by 2
module mul_booth4_step
    import mul_pkg::*;
#(
    parameter int A_W   = 32,
    parameter int ACC_W = A_W + 2 + 34 + 1
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [A_W+1:0]   a_ext_i,
    input  logic [2:0]       op_i,
    output logic [ACC_W-1:0] acc_o
);

    localparam int H_W = A_W + 2;
    localparam int L_W = ACC_W - H_W;

    logic [H_W-1:0] addend;
    logic [H_W-1:0] a_x2;
    logic [H_W-1:0] hi_sum;
    logic           acc_unused;

    assign a_x2 = {a_ext_i[H_W-2:0], 1'b0};

    always_comb begin
        addend = '0;
        case (booth_op_e'(op_i))
            OP_ADD1: addend = a_ext_i;
            OP_ADD2: addend = a_x2;
            OP_SUB1: addend = -a_ext_i;
            OP_SUB2: addend = -a_x2;
            default: addend = '0;
        endcase
    end

    // Wrap at H_W bits is exact thanks to the 2-bit sign guard on a_ext_i.
    assign hi_sum     = acc_i[ACC_W-1 -: H_W] + addend;
    assign acc_o      = {{2{hi_sum[H_W-1]}}, hi_sum, acc_i[L_W-1:2]};
    assign acc_unused = ^acc_i[1:0];

endmodule

// File: rtl/multiply_booth4.sv
// rtl/multiply_booth4.sv - sequential radix-4 Booth multiplier with valid/ready handshake and kill
module multiply_booth4
    import mul_pkg::*;
#(
    parameter int A_W = 32,
    parameter int B_W = 32,
    parameter int O_W = A_W + B_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    input  logic           a_signed,
    input  logic           b_signed,
    input  logic           kill,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [O_W-1:0] o,
    output logic           busy
);

    localparam int N_ITER = (B_W + 2) / 2;
    localparam int ACC_W  = (A_W + 2) + 2 * N_ITER + 1;
    localparam int BX_W   = 2 * N_ITER - B_W;
    localparam int CNT_W  = $clog2(N_ITER + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_ITER - 1);

    mul_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  out_valid_q;
    logic                  busy_q;
    logic [A_W+1:0]        a_q;
    logic [ACC_W-1:0]      acc_q;
    logic [ACC_W-1:0]      acc_d;
    logic [2*N_ITER-1:0]   b_ext;
    logic                  accept;
    booth_op_e             op;
    logic                  acc_unused;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready && !kill;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign b_ext     = {{BX_W{b_signed & b[B_W-1]}}, b};
    assign op        = booth_decode(acc_q[2:0]);
    assign o         = acc_q[O_W:1];
    assign acc_unused = ^{acc_q[ACC_W-1:O_W+1], acc_q[0]};

    mul_booth4_step #(
        .A_W   (A_W),
        .ACC_W (ACC_W)
    ) u_step (
        .acc_i   (acc_q),
        .a_ext_i (a_q),
        .op_i    (op),
        .acc_o   (acc_d)
    );

    // Datapath is not reset; contents only matter once out_valid is high.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q   <= {{2{a_signed & a[A_W-1]}}, a};
            acc_q <= {{(A_W + 2){1'b0}}, b_ext, 1'b0};
        end else if (state_q == BUSY) begin
            acc_q <= acc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (kill) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= BUSY;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                BUSY: begin
                    if (cnt_q == LAST) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (accept) begin
                            state_q <= BUSY;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiply_booth4.sv
// tb/tb_multiply_booth4.sv - directed and reference-model checks for multiply_booth4
module tb_multiply_booth4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          checks = 0;
    int          failures = 0;

    logic        in_valid, in_ready, a_signed, b_signed, kill, out_valid, out_ready, busy;
    logic [31:0] a, b;
    logic [63:0] o;

    logic        s_in_valid, s_as, s_bs, s_kill, s_out_ready;
    logic [15:0] a16, b16, o16;
    logic        rdy16, ov16, busy16;
    logic [23:0] a24;
    logic [7:0]  b8;
    logic [31:0] o32;
    logic        rdy248, ov248, busy248;

    multiply_booth4 #(.A_W(32), .B_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed), .kill(kill),
        .out_valid(out_valid), .out_ready(out_ready), .o(o), .busy(busy)
    );

    multiply_booth4 #(.A_W(16), .B_W(16), .O_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(rdy16),
        .a(a16), .b(b16), .a_signed(s_as), .b_signed(s_bs), .kill(s_kill),
        .out_valid(ov16), .out_ready(s_out_ready), .o(o16), .busy(busy16)
    );

    multiply_booth4 #(.A_W(24), .B_W(8)) dut248 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(rdy248),
        .a(a24), .b(b8), .a_signed(s_as), .b_signed(s_bs), .kill(s_kill),
        .out_valid(ov248), .out_ready(s_out_ready), .o(o32), .busy(busy248)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [63:0] av, input logic [63:0] bv,
                                            input int aw, input int bw, input int ow,
                                            input logic as_, input logic bs_);
        logic signed [127:0] ax, bx, p;
        logic [63:0] mask;
        ax = 128'(av);
        bx = 128'(bv);
        if (as_ && av[aw-1]) ax = ax - (128'sd1 << aw);
        if (bs_ && bv[bw-1]) bx = bx - (128'sd1 << bw);
        p = ax * bx;
        mask = (ow >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << ow) - 64'd1);
        return p[63:0] & mask;
    endfunction

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic as_, input logic bs_, input logic [63:0] exp);
        int lat;
        a = av; b = bv; a_signed = as_; b_signed = bs_; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; a_signed = ~as_; b_signed = ~bs_;
        wait_out(lat);
        check({tag, "_lat"}, 64'(lat), 64'd17);
        check(tag, o, exp);
        step();
    endtask

    initial begin
        int lat;
        logic seen;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0;
        kill = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_as = 1'b0; s_bs = 1'b0; s_kill = 1'b0; s_out_ready = 1'b1;
        a16 = '0; b16 = '0; a24 = '0; b8 = '0;
        #3;
        check("rst_state", {61'd0, out_valid, busy, in_ready}, 64'b001);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_op("uu_ones",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE00000001);
        run_op("ss_ones",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h0000000000000001);
        run_op("su_ones",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFF00000001);
        run_op("ss_min_x1", 32'h80000000, 32'h00000001, 1'b1, 1'b1, 64'hFFFFFFFF80000000);
        run_op("ss_min_sq", 32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h4000000000000000);
        run_op("uu_min_sq", 32'h80000000, 32'h80000000, 1'b0, 1'b0, 64'h4000000000000000);
        run_op("ss_max_min",32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, 64'hC000000080000000);
        run_op("uu_zero",   32'h00000000, 32'hDEADBEEF, 1'b0, 1'b0, 64'h0000000000000000);

        // Back-pressure in DONE, then same-edge accept of the next operation.
        out_ready = 1'b0;
        a = 32'd6; b = 32'd7; a_signed = 1'b0; b_signed = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(lat);
        check("bp_lat", 64'(lat), 64'd17);
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = $urandom;
            step();
            check("bp_hold_o", o, 64'd42);
            check("bp_hold_vr", {62'd0, out_valid, in_ready}, 64'b10);
        end
        out_ready = 1'b1;
        a = 32'd3; b = 32'hFFFFFFFD; a_signed = 1'b1; b_signed = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("b2b_busy", {63'd0, busy}, 64'd1);
        wait_out(lat);
        check("b2b_lat", 64'(lat), 64'd17);
        check("b2b_o", o, 64'hFFFFFFFFFFFFFFF7);
        step();

        // kill mid-iteration, then a fresh op right after.
        a = 32'd100; b = 32'd100; a_signed = 1'b0; b_signed = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (8) step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        check("kill_state", {61'd0, out_valid, busy, in_ready}, 64'b001);
        run_op("post_kill", 32'h00010000, 32'h00000010, 1'b0, 1'b0, 64'h0000000000100000);

        // kill together with in_valid in IDLE must not accept.
        kill = 1'b1; in_valid = 1'b1; a = 32'd5; b = 32'd5;
        step();
        kill = 1'b0; in_valid = 1'b0;
        check("kill_noacc", {62'd0, busy, in_ready}, 64'b01);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            seen = seen | out_valid;
        end
        check("kill_noacc_ov", {63'd0, seen}, 64'd0);

        // Asynchronous reset between clock edges.
        a = 32'd5; b = 32'd5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        check("pre_rst_busy", {63'd0, busy}, 64'd1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst", {61'd0, out_valid, busy, in_ready}, 64'b001);
        #2 rst_n = 1'b1;
        step();
        run_op("post_rst", 32'd7, 32'd9, 1'b0, 1'b0, 64'd63);

        // Narrow configurations against the reference model.
        for (int i = 0; i < 12; i++) begin
            int l16, l8;
            logic g16, g8;
            logic [15:0] r16;
            logic [31:0] r32;
            a16 = $urandom; b16 = $urandom; a24 = $urandom; b8 = $urandom;
            s_as = $urandom_range(0, 1); s_bs = $urandom_range(0, 1);
            if (i == 0) begin a16 = 16'hFFFF; b16 = 16'hFFFF; a24 = 24'hFFFFFF; b8 = 8'hFF; s_as = 1'b1; s_bs = 1'b1; end
            if (i == 1) begin a16 = 16'h8000; b16 = 16'h8000; a24 = 24'h800000; b8 = 8'h80; s_as = 1'b1; s_bs = 1'b0; end
            check("n_ready", {62'd0, rdy16, rdy248}, 64'b11);
            s_in_valid = 1'b1;
            step();
            s_in_valid = 1'b0;
            check("n_busy", {62'd0, busy16, busy248}, 64'b11);
            g16 = 1'b0; g8 = 1'b0; l16 = 0; l8 = 0; r16 = '0; r32 = '0;
            for (int c = 1; c <= 30; c++) begin
                step();
                if (ov16 && !g16) begin g16 = 1'b1; l16 = c; r16 = o16; end
                if (ov248 && !g8) begin g8 = 1'b1; l8 = c; r32 = o32; end
                if (g16 && g8) break;
            end
            check("n16_lat", 64'(l16), 64'd9);
            check("n8_lat", 64'(l8), 64'd5);
            check("n16_o", 64'(r16), ref_mul(64'(a16), 64'(b16), 16, 16, 16, s_as, s_bs));
            check("n248_o", 64'(r32), ref_mul(64'(a24), 64'(b8), 24, 8, 32, s_as, s_bs));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
